cj_cosim: RTL and testbench

//  Co-simulation end-of-test checker beside the SoC test harness. It snoops the memory

---
 rtl/cj_pkg.sv | 27 ++
 rtl/cj_sync_fifo.sv | 71 +++++++
 rtl/cj_cosim.sv | 167 ++++++++++++++++
 tb/tb_cj_cosim.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cj_pkg.sv
// Shared definitions for the co-simulation end-of-test checker.
//  - Result codes carried in tohost[63:1]; tohost[0]=1 marks the end of a test round.
//  - mk_tohost() builds a finished mailbox word from a result code.
//  - cj_event_e names the candidate causes of a tohost update, highest priority last.
package cj_pkg;

   localparam int unsigned PC_W = 64;

   localparam logic [62:0] CODE_PASS     = 63'd1;
   localparam logic [62:0] CODE_TIMEOUT  = 63'd2;
   localparam logic [62:0] CODE_MISMATCH = 63'd3;
   localparam logic [62:0] CODE_OVERFLOW = 63'd4;

   typedef enum logic [2:0] {
      EvNone,
      EvMailbox,
      EvTimeout,
      EvOverflow,
      EvMismatch,
      EvSet
   } cj_event_e;

   function automatic logic [63:0] mk_tohost(input logic [62:0] code);
      return {code, 1'b1};
   endfunction

endpackage

// File: rtl/cj_sync_fifo.sv
// Single-clock FIFO holding retired PCs for one side of the comparison.
// Ports:
//  clock  in   rising-edge clock
//  reset  in   synchronous, active-low; empties the queue
//  push   in   write din (dropped when full unless a pop happens the same cycle)
//  pop    in   discard the head entry (ignored when empty)
//  din    in   WIDTH-bit entry to write
//  dout   out  head entry, valid while empty==0
//  full   out  DEPTH entries held
//  empty  out  no entries held
module cj_sync_fifo
   import cj_pkg::*;
#(
   parameter int unsigned WIDTH = PC_W,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             do_push;
   logic             do_pop;

   assign full  = (level_q == LVL_W'(DEPTH));
   assign empty = (level_q == '0);
   assign dout  = mem_q[rd_ptr_q];

   assign do_pop  = pop & ~empty;
   // A pop frees the slot the push lands in, so push-while-full is fine then.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            level_q <= level_q + LVL_W'(1);
         end else if (do_pop && !do_push) begin
            level_q <= level_q - LVL_W'(1);
         end
      end
   end

endmodule

// File: rtl/cj_cosim.sv
// Co-simulation end-of-test checker. Compares the DUT retired-PC stream with the
// reference-model stream, watches for a store to the tohost mailbox and raises
// timeout / overflow / mismatch results. Once tohost[0] is set everything freezes.
// Ports:
//  clock         in   rising-edge clock
//  reset         in   synchronous, active-low
//  mem_wr_valid  in   store beat valid
//  mem_wr_addr   in   store address (ADDR_W)
//  mem_wr_data   in   store data (64)
//  commit_valid  in   DUT retired one instruction
//  commit_pc     in   PC of that instruction
//  ref_valid     in   reference model retired one instruction
//  ref_pc        in   reference PC
//  set_valid     in   host override of tohost
//  set_value     in   override value (bit0 may be 0)
//  tohost        out  mailbox word, 0 while running
//  mismatch      out  sticky PC compare failure
//  commit_count  out  matched commits, saturating
module cj_cosim
   import cj_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h8000_1000),
   parameter int unsigned       FIFO_DEPTH  = 8,
   parameter int unsigned       TIMEOUT_CYC = 50000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              mem_wr_valid,
   input  logic [ADDR_W-1:0] mem_wr_addr,
   input  logic [63:0]       mem_wr_data,
   input  logic              commit_valid,
   input  logic [63:0]       commit_pc,
   input  logic              ref_valid,
   input  logic [63:0]       ref_pc,
   input  logic              set_valid,
   input  logic [63:0]       set_value,
   output logic [63:0]       tohost,
   output logic              mismatch,
   output logic [31:0]       commit_count
);

   localparam int unsigned IDLE_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

   logic [63:0]       tohost_q, tohost_d;
   logic              mismatch_q, mismatch_d;
   logic [31:0]       count_q, count_d;
   logic [IDLE_W-1:0] idle_q, idle_d;

   logic        done;
   logic        dut_push, ref_push;
   logic        dut_full, ref_full;
   logic        dut_empty, ref_empty;
   logic [63:0] dut_head, ref_head;
   logic        do_cmp;
   logic        cmp_fail;
   logic        overflow;
   logic        timeout_hit;
   logic        mailbox_hit;
   cj_event_e   ev;

   assign done     = tohost_q[0];
   assign dut_push = commit_valid & ~done;
   assign ref_push = ref_valid & ~done;
   // Compare uses the heads present at the start of the cycle; new pushes wait a cycle.
   assign do_cmp   = ~dut_empty & ~ref_empty & ~done;

   cj_sync_fifo #(
      .WIDTH (64),
      .DEPTH (FIFO_DEPTH)
   ) u_dut_fifo (
      .clock (clock),
      .reset (reset),
      .push  (dut_push),
      .pop   (do_cmp),
      .din   (commit_pc),
      .dout  (dut_head),
      .full  (dut_full),
      .empty (dut_empty)
   );

   cj_sync_fifo #(
      .WIDTH (64),
      .DEPTH (FIFO_DEPTH)
   ) u_ref_fifo (
      .clock (clock),
      .reset (reset),
      .push  (ref_push),
      .pop   (do_cmp),
      .din   (ref_pc),
      .dout  (ref_head),
      .full  (ref_full),
      .empty (ref_empty)
   );

   assign cmp_fail    = do_cmp & (dut_head != ref_head);
   // Both queues pop together, so a pop on either side means a pop on the full one.
   assign overflow    = ~do_cmp & ((dut_push & dut_full) | (ref_push & ref_full));
   assign timeout_hit = ~done & ~commit_valid & (idle_q == IDLE_LAST);
   assign mailbox_hit = ~done & mem_wr_valid & (mem_wr_addr == TOHOST_ADDR) & mem_wr_data[0];

   always_comb begin
      ev = EvNone;
      if (done) begin
         ev = EvNone;
      end else if (set_valid) begin
         ev = EvSet;
      end else if (cmp_fail) begin
         ev = EvMismatch;
      end else if (overflow) begin
         ev = EvOverflow;
      end else if (timeout_hit) begin
         ev = EvTimeout;
      end else if (mailbox_hit) begin
         ev = EvMailbox;
      end
   end

   always_comb begin
      tohost_d   = tohost_q;
      mismatch_d = mismatch_q | cmp_fail;
      count_d    = count_q;
      idle_d     = idle_q;

      case (ev)
         EvSet:      tohost_d = set_value;
         EvMismatch: tohost_d = mk_tohost(CODE_MISMATCH);
         EvOverflow: tohost_d = mk_tohost(CODE_OVERFLOW);
         EvTimeout:  tohost_d = mk_tohost(CODE_TIMEOUT);
         EvMailbox:  tohost_d = mem_wr_data;
         default:    tohost_d = tohost_q;
      endcase

      if (do_cmp && !cmp_fail && (count_q != 32'hFFFF_FFFF)) begin
         count_d = count_q + 32'd1;
      end

      // Idle counter parks at its last value so a non-final override keeps timing out.
      if (!done) begin
         if (commit_valid) begin
            idle_d = '0;
         end else if (idle_q != IDLE_LAST) begin
            idle_d = idle_q + IDLE_W'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         tohost_q   <= '0;
         mismatch_q <= 1'b0;
         count_q    <= '0;
         idle_q     <= '0;
      end else begin
         tohost_q   <= tohost_d;
         mismatch_q <= mismatch_d;
         count_q    <= count_d;
         idle_q     <= idle_d;
      end
   end

   assign tohost       = tohost_q;
   assign mismatch     = mismatch_q;
   assign commit_count = count_q;

endmodule

// File: tb/tb_cj_cosim.sv
module tb_cj_cosim;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned TO     = 16;
   localparam logic [31:0] TOHOST = 32'h8000_1000;
   localparam logic [63:0] PC0    = 64'h8000_0000;

   logic        clock;
   logic        reset;
   logic        mem_wr_valid;
   logic [31:0] mem_wr_addr;
   logic [63:0] mem_wr_data;
   logic        commit_valid;
   logic [63:0] commit_pc;
   logic        ref_valid;
   logic [63:0] ref_pc;
   logic        set_valid;
   logic [63:0] set_value;
   logic [63:0] tohost;
   logic        mismatch;
   logic [31:0] commit_count;

   int n_vec;
   int n_err;

   // Reference model state: queues of pending PCs and the published results.
   logic [63:0] q_dut[$];
   logic [63:0] q_ref[$];
   logic [63:0] m_tohost;
   logic        m_mismatch;
   logic [31:0] m_count;
   int          m_idle;

   cj_cosim #(
      .ADDR_W      (32),
      .TOHOST_ADDR (TOHOST),
      .FIFO_DEPTH  (DEPTH),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_addr  (mem_wr_addr),
      .mem_wr_data  (mem_wr_data),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .ref_valid    (ref_valid),
      .ref_pc       (ref_pc),
      .set_valid    (set_valid),
      .set_value    (set_value),
      .tohost       (tohost),
      .mismatch     (mismatch),
      .commit_count (commit_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void model_step(input logic cv, input logic [63:0] cpc,
                                      input logic rv, input logic [63:0] rpc,
                                      input logic wv, input logic [31:0] wa,
                                      input logic [63:0] wd,
                                      input logic sv, input logic [63:0] sval);
      logic [63:0] a, b;
      bit bad, ovf, tmo;
      if (m_tohost[0]) return;
      bad = 0; ovf = 0; tmo = 0;
      if (q_dut.size() != 0 && q_ref.size() != 0) begin
         a = q_dut.pop_front();
         b = q_ref.pop_front();
         if (a != b) bad = 1;
         else if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      end
      if (cv) begin
         if (q_dut.size() == DEPTH) ovf = 1;
         else q_dut.push_back(cpc);
      end
      if (rv) begin
         if (q_ref.size() == DEPTH) ovf = 1;
         else q_ref.push_back(rpc);
      end
      if (cv) m_idle = 0;
      else if (m_idle == TO - 1) tmo = 1;
      else m_idle = m_idle + 1;
      if (bad) m_mismatch = 1'b1;
      if (sv) m_tohost = sval;
      else if (bad) m_tohost = 64'd7;
      else if (ovf) m_tohost = 64'd9;
      else if (tmo) m_tohost = 64'd5;
      else if (wv && wa == TOHOST && wd[0]) m_tohost = wd;
   endfunction

   task automatic clear_inputs();
      mem_wr_valid = 0; mem_wr_addr = '0; mem_wr_data = '0;
      commit_valid = 0; commit_pc = '0; ref_valid = 0; ref_pc = '0;
      set_valid = 0; set_value = '0;
   endtask

   task automatic step(input logic cv, input logic [63:0] cpc,
                       input logic rv, input logic [63:0] rpc,
                       input logic wv, input logic [31:0] wa, input logic [63:0] wd,
                       input logic sv, input logic [63:0] sval);
      commit_valid = cv; commit_pc = cpc; ref_valid = rv; ref_pc = rpc;
      mem_wr_valid = wv; mem_wr_addr = wa; mem_wr_data = wd;
      set_valid = sv; set_value = sval;
      model_step(cv, cpc, rv, rpc, wv, wa, wd, sv, sval);
      @(posedge clock);
      #1;
      clear_inputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 0;
      @(posedge clock);
      #1;
      reset = 1;
      q_dut.delete(); q_ref.delete();
      m_tohost = '0; m_mismatch = 0; m_count = '0; m_idle = 0;
   endtask

   task automatic pass_seq();
      for (int i = 0; i < 3; i++) step(1, PC0 + 64'(4 * i), 1, PC0 + 64'(4 * i), 0, 0, 0, 0, 0);
      idle(1);
      step(0, 0, 0, 0, 1, TOHOST, 64'd1, 0, 0);
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (tohost !== 64'd0) begin n_err++; $display("FAIL reset_tohost: got %h want 0", tohost); end
      n_vec++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL reset_mismatch: got %b want 0", mismatch); end
      n_vec++; if (commit_count !== 32'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", commit_count); end
   endtask

   task automatic test_pass();
      do_reset();
      for (int i = 0; i < 3; i++) step(1, PC0 + 64'(4 * i), 1, PC0 + 64'(4 * i), 0, 0, 0, 0, 0);
      idle(1);
      n_vec++; if (tohost !== 64'd0) begin n_err++; $display("FAIL pass_running: got %h want 0", tohost); end
      step(0, 0, 0, 0, 1, TOHOST, 64'd1, 0, 0);
      n_vec++; if (tohost !== 64'd1) begin n_err++; $display("FAIL pass_tohost: got %h want 1", tohost); end
      n_vec++; if (commit_count !== 32'd3) begin n_err++; $display("FAIL pass_count: got %0d want 3", commit_count); end
      n_vec++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL pass_mismatch: got %b want 0", mismatch); end
   endtask

   task automatic test_mismatch();
      do_reset();
      step(1, 64'h8000_0004, 1, 64'h8000_0008, 0, 0, 0, 0, 0);
      n_vec++; if (tohost !== 64'd0) begin n_err++; $display("FAIL mm_before: got %h want 0", tohost); end
      idle(1);
      n_vec++; if (tohost !== 64'd7) begin n_err++; $display("FAIL mm_tohost: got %h want 7", tohost); end
      n_vec++; if (mismatch !== 1'b1) begin n_err++; $display("FAIL mm_flag: got %b want 1", mismatch); end
      step(0, 0, 0, 0, 1, TOHOST, 64'd1, 0, 0);
      n_vec++; if (tohost !== 64'd7) begin n_err++; $display("FAIL mm_frozen: got %h want 7", tohost); end
      n_vec++; if (commit_count !== 32'd0) begin n_err++; $display("FAIL mm_count: got %0d want 0", commit_count); end
   endtask

   task automatic test_timeout();
      do_reset();
      idle(TO - 1);
      n_vec++; if (tohost !== 64'd0) begin n_err++; $display("FAIL to_early: got %h want 0", tohost); end
      idle(1);
      n_vec++; if (tohost !== 64'd5) begin n_err++; $display("FAIL to_fire: got %h want 5", tohost); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, PC0 + 64'(4 * i), 0, 0, 0, 0, 0, 0, 0);
      n_vec++; if (tohost !== 64'd0) begin n_err++; $display("FAIL ovf_full: got %h want 0", tohost); end
      step(1, PC0 + 64'(4 * DEPTH), 0, 0, 0, 0, 0, 0, 0);
      n_vec++; if (tohost !== 64'd9) begin n_err++; $display("FAIL ovf_fire: got %h want 9", tohost); end
   endtask

   task automatic test_priority();
      do_reset();
      step(0, 0, 0, 0, 1, TOHOST, 64'd1, 1, 64'd5);
      n_vec++; if (tohost !== 64'd5) begin n_err++; $display("FAIL prio_set: got %h want 5", tohost); end
      do_reset();
      step(0, 0, 0, 0, 1, TOHOST + 32'd8, 64'd1, 0, 0);
      n_vec++; if (tohost !== 64'd0) begin n_err++; $display("FAIL mbox_addr: got %h want 0", tohost); end
      step(0, 0, 0, 0, 1, TOHOST, 64'd2, 0, 0);
      n_vec++; if (tohost !== 64'd0) begin n_err++; $display("FAIL mbox_bit0: got %h want 0", tohost); end
      step(0, 0, 0, 0, 0, 0, 0, 1, 64'h20);
      n_vec++; if (tohost !== 64'h20) begin n_err++; $display("FAIL set_even: got %h want 20", tohost); end
      step(0, 0, 0, 0, 1, TOHOST, 64'd3, 0, 0);
      n_vec++; if (tohost !== 64'd3) begin n_err++; $display("FAIL mbox_after_set: got %h want 3", tohost); end
   endtask

   task automatic test_reset_mid_run();
      do_reset();
      step(1, PC0, 1, PC0 + 64'h40, 0, 0, 0, 0, 0);
      step(1, PC0 + 64'd4, 0, 0, 0, 0, 0, 0, 0);
      step(1, PC0 + 64'd8, 0, 0, 0, 0, 0, 0, 0);
      n_vec++; if (tohost !== 64'd7) begin n_err++; $display("FAIL mid_tohost: got %h want 7", tohost); end
      do_reset();
      n_vec++; if (tohost !== 64'd0) begin n_err++; $display("FAIL mid_rst_tohost: got %h want 0", tohost); end
      n_vec++; if (mismatch !== 1'b0) begin n_err++; $display("FAIL mid_rst_mm: got %b want 0", mismatch); end
      n_vec++; if (commit_count !== 32'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d want 0", commit_count); end
      pass_seq();
      n_vec++; if (tohost !== 64'd1) begin n_err++; $display("FAIL mid_pass: got %h want 1", tohost); end
      n_vec++; if (commit_count !== 32'd3) begin n_err++; $display("FAIL mid_pass_count: got %0d want 3", commit_count); end
   endtask

   task automatic test_random();
      for (int r = 0; r < 6; r++) begin
         int dseq, rseq;
         dseq = 0; rseq = 0;
         do_reset();
         for (int c = 0; c < 150; c++) begin
            logic cv, rv, wv, sv;
            logic [63:0] cpc, rpc, wd, sval;
            logic [31:0] wa;
            cv = ($urandom_range(0, 99) < 55);
            rv = ($urandom_range(0, 99) < 55);
            cpc = PC0 + 64'(4 * dseq);
            rpc = PC0 + 64'(4 * rseq);
            if ($urandom_range(0, 99) < 2) rpc = rpc ^ 64'h4;
            if (cv) dseq++;
            if (rv) rseq++;
            wv = ($urandom_range(0, 99) < 4);
            wa = ($urandom_range(0, 1) == 1) ? TOHOST : $urandom();
            wd = {$urandom(), $urandom()};
            sv = ($urandom_range(0, 99) < 1);
            sval = {$urandom(), $urandom()};
            step(cv, cpc, rv, rpc, wv, wa, wd, sv, sval);
            n_vec++;
            if (tohost !== m_tohost) begin
               n_err++; $display("FAIL rnd_tohost r%0d c%0d: got %h want %h", r, c, tohost, m_tohost);
            end
            n_vec++;
            if (mismatch !== m_mismatch) begin
               n_err++; $display("FAIL rnd_mismatch r%0d c%0d: got %b want %b", r, c, mismatch, m_mismatch);
            end
            n_vec++;
            if (commit_count !== m_count) begin
               n_err++; $display("FAIL rnd_count r%0d c%0d: got %0d want %0d", r, c, commit_count, m_count);
            end
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 0;
      clear_inputs();
      test_reset();
      test_pass();
      test_mismatch();
      test_timeout();
      test_overflow();
      test_priority();
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
